l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Two-port request arbiter that sits directly upstream of the L2 cache datapath/controller. It merges the L1 I-cache (read-only) and L1 D-cache (read/write) miss ports onto the single L2 port (mem_address, l2_wdata, l2_mem_rdata, l2_read, l2_write, l2_resp). It latches the winning request, holds it stable until L2 responds, and routes the response back to the requester. Round-robin arbitration prevents either L1 from starving the other.

## Interface
- RR_EN, default 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, D-cache wins.

- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request; held until i_resp
- i_address  in  16 (lc3b_word)  I-cache request address
- i_rdata  out  128 (lc3b_cacheline)  read line to I-cache; valid only when i_resp=1
- i_resp  out  1  I-cache request complete
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write request; if d_read is also 1, write takes precedence
- d_address  in  16  D-cache request address
- d_wdata  in  128  D-cache write line
- d_rdata  out  128  read line to D-cache; valid only when d_resp=1
- d_resp  out  1  D-cache request complete
- l2_read  out  1  read command to L2
- l2_write  out  1  write command to L2
- mem_address  out  16  latched request address to L2
- l2_wdata  out  128  latched write line to L2
- l2_mem_rdata  in  128  L2 read line
- l2_resp  in  1  L2 operation complete (single-cycle pulse)

## Operation
- The FSM has four states: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE:
  - Sample requests.
  - i only → SERVE_I.
  - d (read or write) only → SERVE_D.
  - Both, RR_EN=1 → grant the port not recorded in last_grant.
  - Both, RR_EN=0 → SERVE_D.
  - None → stay in IDLE.
- On the grant edge:
  - Latch the address into mem_address.
  - Latch d_wdata into l2_wdata (SERVE_D write only).
  - Latch the op type into the op register: read or write.
  - Update last_grant to the granted port.
- SERVE_I:
  - l2_read=1, l2_write=0.
  - Hold until l2_resp=1.
  - In that cycle i_resp=1 combinationally; then → RECOVER.
- SERVE_D:
  - l2_read / l2_write follow the latched op; exactly one is 1.
  - Hold until l2_resp.
  - In that cycle d_resp=1; then → RECOVER.
- RECOVER:
  - One cycle with no L2 command and no sampling, so the requester can drop its request.
  - Then → IDLE.
- i_rdata and d_rdata both equal l2_mem_rdata at all times. Validity is indicated only by the corresponding resp.
- Latched address and wdata are frozen for the whole SERVE state. Input changes after the grant are ignored.
- A request deasserted mid-service is illegal. The arbiter still completes the latched L2 operation, and the resp pulse is still issued.
- l2_resp outside SERVE_I/SERVE_D is ignored and produces no resp.
- l2_read and l2_write are never both 1. i_resp and d_resp are never both 1.
- Reset (asynchronous, any state, including mid-service):
  - State = IDLE, last_grant = D, so I wins the first tie.
  - l2_read = l2_write = 0, i_resp = d_resp = 0.
  - mem_address = 16'h0000, l2_wdata = 128'h0.
  - Any in-flight L2 operation is abandoned.

## Timing
- Request present in IDLE at edge k → L2 command asserted in cycle k+1 (registered address and command).
- L2 command asserted for cycles k+1 … N, where N is the cycle with l2_resp=1 (N ≥ k+1).
- i_resp/d_resp = 1 in cycle N only (same cycle as l2_resp, zero added latency).
- Cycle N+1 is RECOVER: all commands and resps are 0.
- Cycle N+2: IDLE samples again.
- Minimum turnaround between back-to-back grants: 3 cycles, given an L2 response in the first command cycle.
- l2_read/l2_write/mem_address/l2_wdata come from flops. The resp outputs are combinational from state and l2_resp.

## Test plan
- I-only read:
  - Stimulus: i_read=1, i_address=16'h1230; L2 gives l2_resp after 3 cycles with l2_mem_rdata=128'hA5…A5.
  - Required: l2_read=1 with mem_address=16'h1230 from the cycle after the request; i_resp=1 for exactly one cycle with i_rdata=A5…A5; d_resp stays 0.
- D write:
  - Stimulus: d_write=1, d_address=16'h8840, d_wdata=128'h0123…CDEF.
  - Required: l2_write=1, l2_read=0, l2_wdata=0123…CDEF, held until l2_resp; d_resp pulses once; then one RECOVER cycle.
- Simultaneous requests after reset, RR_EN=1:
  - Stimulus: i_read and d_read both held.
  - Required: grant order I, D, I, D over 4 transactions; each grant begins exactly 2 cycles after the previous l2_resp.
- RR_EN=0, both requests held:
  - Required: D is granted first; I is granted after D drops its request.
- Input change during service:
  - Stimulus: d_address changed from 16'h0010 to 16'hFFF0 mid-service; d_read and d_write both asserted.
  - Required: mem_address stays 16'h0010; only l2_write asserts.
- Reset mid-service:
  - Stimulus: assert reset while in SERVE_D with l2_write=1.
  - Required: within the same cycle, l2_write=0, mem_address=0, resps=0; after release the FSM is in IDLE and a pending i_read wins the tie.

Source files
------------

// File: rtl/l2_arbiter_if.sv
// Bundles the I-cache, D-cache and L2 miss-port signals around l2_arbiter.
// The arbiter takes the slave view; the surrounding L1/L2 logic takes the master view.
interface l2_arbiter_if;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;

  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;

  logic         l2_read;
  logic         l2_write;
  logic [15:0]  mem_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_mem_rdata;
  logic         l2_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_mem_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, mem_address, l2_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_mem_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, mem_address, l2_wdata
  );
endinterface

// File: rtl/l2_arbiter.sv
// Merges the L1 I-cache and D-cache miss ports onto one L2 port. The winning request is
// latched on the grant edge and held until L2 responds; ties are round-robin or D-first.
module l2_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic         clk,
  input logic         reset,
  l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD, StRecover} state_e;

  state_e       state_q, state_d;
  logic         last_d_q, last_d_d;  // 1: D-cache held the most recent grant
  logic         l2_read_q, l2_read_d;
  logic         l2_write_q, l2_write_d;
  logic [15:0]  mem_address_q, mem_address_d;
  logic [127:0] l2_wdata_q, l2_wdata_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Requests are only sampled in idle, so grants are zero everywhere else.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (i_req && d_req) begin
        grant_d = RR_EN ? last_d_q == 1'b0 : 1'b1;
      end else begin
        grant_d = d_req;
      end
      grant_i = i_req & ~grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    l2_read_d     = l2_read_q;
    l2_write_d    = l2_write_q;
    mem_address_d = mem_address_q;
    l2_wdata_d    = l2_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d       = StServeD;
          last_d_d      = 1'b1;
          mem_address_d = bus.d_address;
          // Write wins when the D-cache raises both read and write.
          l2_write_d    = bus.d_write;
          l2_read_d     = ~bus.d_write;
          if (bus.d_write) begin
            l2_wdata_d = bus.d_wdata;
          end
        end else if (grant_i) begin
          state_d       = StServeI;
          last_d_d      = 1'b0;
          mem_address_d = bus.i_address;
          l2_read_d     = 1'b1;
          l2_write_d    = 1'b0;
        end
      end
      StServeI, StServeD: begin
        if (bus.l2_resp) begin
          state_d    = StRecover;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      last_d_q      <= 1'b1;
      l2_read_q     <= 1'b0;
      l2_write_q    <= 1'b0;
      mem_address_q <= 16'h0000;
      l2_wdata_q    <= 128'h0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      l2_read_q     <= l2_read_d;
      l2_write_q    <= l2_write_d;
      mem_address_q <= mem_address_d;
      l2_wdata_q    <= l2_wdata_d;
    end
  end

  assign bus.l2_read     = l2_read_q;
  assign bus.l2_write    = l2_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.l2_wdata    = l2_wdata_q;

  // Zero-latency completion: resp mirrors l2_resp while serving that port.
  assign bus.i_resp  = (state_q == StServeI) & bus.l2_resp;
  assign bus.d_resp  = (state_q == StServeD) & bus.l2_resp;
  assign bus.i_rdata = bus.l2_mem_rdata;
  assign bus.d_rdata = bus.l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: one round-robin instance and one fixed-priority instance
// driven from hand-written vectors, checked against hand-computed values.
module tb_l2_arbiter;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  l2_arbiter_if bus_rr ();
  l2_arbiter_if bus_fp ();

  l2_arbiter #(.RR_EN(1'b1)) u_rr (.clk(clk), .reset(reset), .bus(bus_rr.slave));
  l2_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .reset(reset), .bus(bus_fp.slave));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] PatA5 = {16{8'hA5}};
  localparam logic [127:0] PatWr = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    reset = 1'b1;
    bus_rr.i_read = 1'b0; bus_rr.i_address = '0;
    bus_rr.d_read = 1'b0; bus_rr.d_write = 1'b0; bus_rr.d_address = '0; bus_rr.d_wdata = '0;
    bus_rr.l2_mem_rdata = '0; bus_rr.l2_resp = 1'b0;
    bus_fp.i_read = 1'b0; bus_fp.i_address = '0;
    bus_fp.d_read = 1'b0; bus_fp.d_write = 1'b0; bus_fp.d_address = '0; bus_fp.d_wdata = '0;
    bus_fp.l2_mem_rdata = '0; bus_fp.l2_resp = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_l2_read", bus_rr.l2_read, 0);
    check_eq("rst_l2_write", bus_rr.l2_write, 0);
    check_eq("rst_mem_address", bus_rr.mem_address, 0);
    check_eq("rst_l2_wdata", bus_rr.l2_wdata, 0);
    check_eq("rst_resps", {bus_rr.i_resp, bus_rr.d_resp}, 0);
    @(negedge clk);
    reset = 1'b0;

    // I-only read, response in the third command cycle
    @(negedge clk);
    bus_rr.i_read = 1'b1; bus_rr.i_address = 16'h1230;
    @(negedge clk); #1;
    check_eq("i_cmd_read", {bus_rr.l2_read, bus_rr.l2_write}, 2'b10);
    check_eq("i_cmd_addr", bus_rr.mem_address, 16'h1230);
    check_eq("i_no_early_resp", bus_rr.i_resp, 0);
    @(negedge clk); #1;
    check_eq("i_cmd_held", bus_rr.l2_read, 1);
    @(negedge clk);
    bus_rr.l2_resp = 1'b1; bus_rr.l2_mem_rdata = PatA5;
    #1;
    check_eq("i_resp", bus_rr.i_resp, 1);
    check_eq("i_rdata", bus_rr.i_rdata, PatA5);
    check_eq("i_d_resp_quiet", bus_rr.d_resp, 0);
    @(negedge clk);
    bus_rr.l2_resp = 1'b0; bus_rr.i_read = 1'b0;
    #1;
    check_eq("i_recover_resp", bus_rr.i_resp, 0);
    check_eq("i_recover_cmd", {bus_rr.l2_read, bus_rr.l2_write}, 0);
    @(negedge clk);

    // D write; a stray l2_resp during recover must not produce d_resp
    bus_rr.d_write = 1'b1; bus_rr.d_address = 16'h8840; bus_rr.d_wdata = PatWr;
    @(negedge clk); #1;
    check_eq("dw_cmd", {bus_rr.l2_read, bus_rr.l2_write}, 2'b01);
    check_eq("dw_addr", bus_rr.mem_address, 16'h8840);
    check_eq("dw_wdata", bus_rr.l2_wdata, PatWr);
    @(negedge clk); #1;
    check_eq("dw_cmd_held", {bus_rr.l2_read, bus_rr.l2_write, bus_rr.d_resp}, 3'b010);
    bus_rr.l2_resp = 1'b1;
    #1;
    check_eq("dw_resp", {bus_rr.i_resp, bus_rr.d_resp}, 2'b01);
    @(negedge clk);
    bus_rr.d_write = 1'b0;
    #1;
    check_eq("dw_recover_cmd", {bus_rr.l2_read, bus_rr.l2_write}, 0);
    check_eq("stray_resp_ignored", {bus_rr.i_resp, bus_rr.d_resp}, 0);
    @(negedge clk);
    bus_rr.l2_resp = 1'b0;

    // Simultaneous requests after reset: I, D, I, D with 3-cycle turnaround
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_rr.i_read = 1'b1; bus_rr.i_address = 16'h1000;
    bus_rr.d_read = 1'b1; bus_rr.d_address = 16'h2000;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); #1;
      check_eq($sformatf("rr%0d_cmd", t), {bus_rr.l2_read, bus_rr.l2_write}, 2'b10);
      check_eq($sformatf("rr%0d_addr", t), bus_rr.mem_address,
               (t % 2 == 0) ? 16'h1000 : 16'h2000);
      bus_rr.l2_resp = 1'b1; bus_rr.l2_mem_rdata = {4{32'hC0DE0000 + 32'(t)}};
      #1;
      check_eq($sformatf("rr%0d_resp", t), {bus_rr.i_resp, bus_rr.d_resp},
               (t % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
      bus_rr.l2_resp = 1'b0;
      #1;
      check_eq($sformatf("rr%0d_recover", t), bus_rr.l2_read, 0);
      @(negedge clk); #1;
      check_eq($sformatf("rr%0d_idle", t), bus_rr.l2_read, 0);
      if (t == 3) begin
        bus_rr.i_read = 1'b0; bus_rr.d_read = 1'b0;
      end
    end

    // Fixed priority: D first, I only once D drops
    bus_fp.i_read = 1'b1; bus_fp.i_address = 16'h3000;
    bus_fp.d_read = 1'b1; bus_fp.d_address = 16'h4000;
    @(negedge clk); #1;
    check_eq("fp_first_addr", bus_fp.mem_address, 16'h4000);
    bus_fp.l2_resp = 1'b1;
    #1;
    check_eq("fp_first_resp", {bus_fp.i_resp, bus_fp.d_resp}, 2'b01);
    @(negedge clk);
    bus_fp.l2_resp = 1'b0; bus_fp.d_read = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("fp_second_addr", bus_fp.mem_address, 16'h3000);
    check_eq("fp_second_cmd", {bus_fp.l2_read, bus_fp.l2_write}, 2'b10);
    bus_fp.l2_resp = 1'b1;
    #1;
    check_eq("fp_second_resp", {bus_fp.i_resp, bus_fp.d_resp}, 2'b10);
    @(negedge clk);
    bus_fp.l2_resp = 1'b0; bus_fp.i_read = 1'b0;
    @(negedge clk);

    // Inputs changed mid-service are ignored; write beats read
    bus_rr.d_read = 1'b1; bus_rr.d_write = 1'b1; bus_rr.d_address = 16'h0010;
    @(negedge clk); #1;
    check_eq("chg_cmd", {bus_rr.l2_read, bus_rr.l2_write}, 2'b01);
    bus_rr.d_address = 16'hFFF0; bus_rr.d_write = 1'b0;
    @(negedge clk); #1;
    check_eq("chg_addr_frozen", bus_rr.mem_address, 16'h0010);
    check_eq("chg_cmd_frozen", {bus_rr.l2_read, bus_rr.l2_write}, 2'b01);
    bus_rr.l2_resp = 1'b1;
    #1;
    check_eq("chg_resp", bus_rr.d_resp, 1);
    @(negedge clk);
    bus_rr.l2_resp = 1'b0; bus_rr.d_read = 1'b0;
    @(negedge clk);

    // Reset mid-service, then a pending I read wins the tie
    bus_rr.d_write = 1'b1; bus_rr.d_address = 16'h5550; bus_rr.d_wdata = PatA5;
    @(negedge clk); #1;
    check_eq("rms_cmd", bus_rr.l2_write, 1);
    bus_rr.i_read = 1'b1; bus_rr.i_address = 16'h7770;
    #1;
    reset = 1'b1; bus_rr.l2_resp = 1'b1;
    #1;
    check_eq("rms_cmd_cleared", {bus_rr.l2_read, bus_rr.l2_write}, 0);
    check_eq("rms_addr_cleared", bus_rr.mem_address, 0);
    check_eq("rms_wdata_cleared", bus_rr.l2_wdata, 0);
    check_eq("rms_resps", {bus_rr.i_resp, bus_rr.d_resp}, 0);
    @(negedge clk);
    bus_rr.l2_resp = 1'b0; reset = 1'b0;
    @(negedge clk); #1;
    check_eq("rms_tie_cmd", {bus_rr.l2_read, bus_rr.l2_write}, 2'b10);
    check_eq("rms_tie_addr", bus_rr.mem_address, 16'h7770);
    bus_rr.l2_resp = 1'b1;
    #1;
    check_eq("rms_tie_resp", {bus_rr.i_resp, bus_rr.d_resp}, 2'b10);
    @(negedge clk);
    bus_rr.l2_resp = 1'b0; bus_rr.i_read = 1'b0; bus_rr.d_write = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
